// File: rtl/mcu_debug_sequencer_pkg.sv
// Shared types for the MCU debug sequencer.
//   state_t    : sequencer FSM states
//   cmd_t      : decoded one-shot debug command
//   SIZE_*     : memory access size encodings (byte/half/word)
//   cmd_encode : priority encoder for the command strobes
//                (reset > pause > resume > mem rd/wr > reg rd/wr)
package dbg_pkg;

  typedef enum logic [2:0] {
    S_RUN, S_HALT_PEND, S_HALTED, S_MEM, S_REG, S_RST
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE, CMD_RESET, CMD_PAUSE, CMD_RESUME,
    CMD_MEM_RD, CMD_MEM_WR, CMD_REG_RD, CMD_REG_WR
  } cmd_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic cmd_t cmd_encode(
    input logic c_reset, c_pause, c_resume,
    input logic c_mem_rd, c_mem_wr, c_reg_rd, c_reg_wr
  );
    if (c_reset)  return CMD_RESET;
    if (c_pause)  return CMD_PAUSE;
    if (c_resume) return CMD_RESUME;
    if (c_mem_rd) return CMD_MEM_RD;
    if (c_mem_wr) return CMD_MEM_WR;
    if (c_reg_rd) return CMD_REG_RD;
    if (c_reg_wr) return CMD_REG_WR;
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/mcu_debug_sequencer_mem_mux.sv
// dbg_mem_mux: shares the single memory port between the core and the debugger.
//   dbg_pend/dbg_hold/halted/mask : debugger wants port / already owns it /
//                                   core halted / starvation mask active
//   dbg_* access fields           : latched debug access
//   core_mem_*                    : core request in, ack/rdata out
//   mem_*                         : shared memory port
//   dbg_own                       : debugger drives the port this cycle
//   core_txn                      : a forwarded core access is awaiting ack
module dbg_mem_mux (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        dbg_pend,
  input  logic        dbg_hold,
  input  logic        halted,
  input  logic        mask,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic [1:0]  dbg_size,
  input  logic        core_mem_req,
  input  logic        core_mem_we,
  input  logic [31:0] core_mem_addr,
  input  logic [31:0] core_mem_wdata,
  input  logic [1:0]  core_mem_size,
  output logic        core_mem_ack,
  output logic [31:0] core_mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        dbg_own,
  output logic        core_txn
);

  logic core_req_eff;
  logic core_sel;

  // The mask only blocks *new* core requests; an in-flight one keeps its
  // request up so memory can finish it and free the port.
  assign core_req_eff = core_mem_req && !(mask && !core_txn);
  assign dbg_own = dbg_pend &&
                   (dbg_hold || (!core_txn && (halted || !core_req_eff)));
  assign core_sel = !rst && !dbg_own && core_req_eff;

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_size  = '0;
    if (!rst && dbg_own) begin
      mem_req   = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_size  = dbg_size;
    end else if (core_sel) begin
      mem_req   = 1'b1;
      mem_we    = core_mem_we;
      mem_addr  = core_mem_addr;
      mem_wdata = core_mem_wdata;
      mem_size  = core_mem_size;
    end
  end

  assign core_mem_ack   = core_sel && mem_ack;
  assign core_mem_rdata = core_sel ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst || clear)             core_txn <= 1'b0;
    else if (core_sel && mem_ack) core_txn <= 1'b0;
    else if (core_sel)            core_txn <= 1'b1;
  end

endmodule

// File: rtl/mcu_debug_sequencer.sv
// mcu_debug_sequencer: turns one-shot debug commands into core control,
// shared-memory accesses and register-file accesses.
//   dbg_*   : command strobe/fields in, busy flag and read result out
//   core_*  : halt/reset control, boundary status, core memory request
//   mem_*   : shared memory port (owned by core or debugger)
//   rf_*    : register-file debug port
module mcu_debug_sequencer
  import dbg_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int STARVE_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbg_valid,
  input  logic        dbg_pause,
  input  logic        dbg_resume,
  input  logic        dbg_reset,
  input  logic        dbg_mem_rd,
  input  logic        dbg_mem_wr,
  input  logic        dbg_reg_rd,
  input  logic        dbg_reg_wr,
  input  logic [1:0]  dbg_mem_size,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_busy,
  output logic [31:0] dbg_rdata,
  input  logic        core_boundary,
  output logic        core_halt,
  output logic        core_rst,
  input  logic        core_mem_req,
  input  logic        core_mem_we,
  input  logic [31:0] core_mem_addr,
  input  logic [31:0] core_mem_wdata,
  input  logic [1:0]  core_mem_size,
  output logic        core_mem_ack,
  output logic [31:0] core_mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  rf_addr,
  output logic        rf_we,
  output logic [31:0] rf_wdata,
  input  logic [31:0] rf_rdata
);

  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  state_t        state, state_n;
  logic          halted, halted_n;
  logic          core_halt_n, core_rst_n;
  logic [CW-1:0] rst_cnt, rst_cnt_n;
  logic [SW-1:0] starve, starve_n;
  logic          granted, granted_n;
  logic [31:0]   rdata_n;
  logic          r_we, r_we_n;
  logic [31:0]   r_addr, r_addr_n, r_wdata, r_wdata_n;
  logic [1:0]    r_size, r_size_n;
  logic          dbg_own, core_txn, mask;
  cmd_t          cmd;

  assign cmd = cmd_encode(dbg_reset, dbg_pause, dbg_resume, dbg_mem_rd,
                          dbg_mem_wr, dbg_reg_rd, dbg_reg_wr);
  assign dbg_busy = dbg_valid || !(state == S_RUN || state == S_HALTED);
  assign mask = (state == S_MEM) && (starve == SW'(STARVE_MAX));

  assign rf_addr  = (state == S_REG) ? r_addr[4:0] : 5'd0;
  assign rf_wdata = (state == S_REG) ? r_wdata : '0;
  assign rf_we    = (state == S_REG) && r_we && (r_addr[4:0] != 5'd0);

  dbg_mem_mux u_mux (
    .clk(clk), .rst(rst), .clear(state == S_RST),
    .dbg_pend(state == S_MEM), .dbg_hold(granted), .halted(halted),
    .mask(mask), .dbg_we(r_we), .dbg_addr(r_addr), .dbg_wdata(r_wdata),
    .dbg_size(r_size),
    .core_mem_req(core_mem_req), .core_mem_we(core_mem_we),
    .core_mem_addr(core_mem_addr), .core_mem_wdata(core_mem_wdata),
    .core_mem_size(core_mem_size), .core_mem_ack(core_mem_ack),
    .core_mem_rdata(core_mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .dbg_own(dbg_own), .core_txn(core_txn)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      halted    <= 1'b0;
      core_halt <= 1'b0;
      core_rst  <= 1'b0;
      rst_cnt   <= '0;
      starve    <= '0;
      granted   <= 1'b0;
      dbg_rdata <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_size    <= '0;
    end else begin
      state     <= state_n;
      halted    <= halted_n;
      core_halt <= core_halt_n;
      core_rst  <= core_rst_n;
      rst_cnt   <= rst_cnt_n;
      starve    <= starve_n;
      granted   <= granted_n;
      dbg_rdata <= rdata_n;
      r_we      <= r_we_n;
      r_addr    <= r_addr_n;
      r_wdata   <= r_wdata_n;
      r_size    <= r_size_n;
    end
  end

  always_comb begin
    state_n     = state;
    halted_n    = halted;
    core_halt_n = core_halt;
    core_rst_n  = core_rst;
    rst_cnt_n   = rst_cnt;
    starve_n    = starve;
    granted_n   = granted;
    rdata_n     = dbg_rdata;
    r_we_n      = r_we;
    r_addr_n    = r_addr;
    r_wdata_n   = r_wdata;
    r_size_n    = r_size;

    case (state)
      S_RUN, S_HALTED: begin
        if (dbg_valid) begin
          case (cmd)
            CMD_RESET: begin
              state_n    = S_RST;
              core_rst_n = 1'b1;
              rst_cnt_n  = CW'(RST_CYCLES - 1);
              starve_n   = '0;
              granted_n  = 1'b0;
            end
            CMD_PAUSE: begin
              if (!halted) begin
                state_n     = S_HALT_PEND;
                core_halt_n = 1'b1;
              end
            end
            CMD_RESUME: begin
              state_n     = S_RUN;
              halted_n    = 1'b0;
              core_halt_n = 1'b0;
            end
            CMD_MEM_RD, CMD_MEM_WR: begin
              state_n   = S_MEM;
              r_we_n    = (cmd == CMD_MEM_WR);
              r_addr_n  = dbg_addr;
              r_wdata_n = dbg_wdata;
              r_size_n  = dbg_mem_size;
            end
            CMD_REG_RD, CMD_REG_WR: begin
              if (halted) begin
                state_n   = S_REG;
                r_we_n    = (cmd == CMD_REG_WR);
                r_addr_n  = dbg_addr;
                r_wdata_n = dbg_wdata;
              end else begin
                rdata_n = '0;
              end
            end
            default: ;
          endcase
        end
      end
      S_HALT_PEND: begin
        // A reset is still honoured here: it is the only way out of a
        // pause whose core never reaches a boundary.
        if (dbg_valid && cmd == CMD_RESET) begin
          state_n    = S_RST;
          core_rst_n = 1'b1;
          rst_cnt_n  = CW'(RST_CYCLES - 1);
          starve_n   = '0;
          granted_n  = 1'b0;
        end else if (core_boundary && !core_txn) begin
          state_n  = S_HALTED;
          halted_n = 1'b1;
        end
      end
      S_MEM: begin
        if (dbg_own) begin
          starve_n = '0;
          if (mem_ack) begin
            if (!r_we) rdata_n = mem_rdata;
            granted_n = 1'b0;
            state_n   = halted ? S_HALTED : S_RUN;
          end else begin
            granted_n = 1'b1;
          end
        end else if (starve != SW'(STARVE_MAX)) begin
          starve_n = starve + SW'(1);
        end
      end
      S_REG: begin
        if (!r_we) rdata_n = rf_rdata;
        state_n = S_HALTED;
      end
      S_RST: begin
        if (rst_cnt == '0) begin
          state_n     = S_RUN;
          core_rst_n  = 1'b0;
          core_halt_n = 1'b0;
          halted_n    = 1'b0;
        end else begin
          rst_cnt_n = rst_cnt - CW'(1);
        end
      end
      default: state_n = S_RUN;
    endcase
  end

endmodule

// File: tb/tb_mcu_debug_sequencer.sv
// Self-checking bench for mcu_debug_sequencer with a 2-cycle-ack memory
// model, a register-file model and read/write scoreboards.
module tb_mcu_debug_sequencer;
  import dbg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic dbg_valid, dbg_pause, dbg_resume, dbg_reset;
  logic dbg_mem_rd, dbg_mem_wr, dbg_reg_rd, dbg_reg_wr;
  logic [1:0]  dbg_mem_size;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_busy;
  logic [31:0] dbg_rdata;
  logic        core_boundary, core_halt, core_rst;
  logic        core_mem_req, core_mem_we, core_mem_ack;
  logic [31:0] core_mem_addr, core_mem_wdata, core_mem_rdata;
  logic [1:0]  core_mem_size;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;
  logic [4:0]  rf_addr;
  logic        rf_we;
  logic [31:0] rf_wdata, rf_rdata;

  always #5 clk = ~clk;

  mcu_debug_sequencer dut (
    .clk(clk), .rst(rst), .dbg_valid(dbg_valid), .dbg_pause(dbg_pause),
    .dbg_resume(dbg_resume), .dbg_reset(dbg_reset), .dbg_mem_rd(dbg_mem_rd),
    .dbg_mem_wr(dbg_mem_wr), .dbg_reg_rd(dbg_reg_rd), .dbg_reg_wr(dbg_reg_wr),
    .dbg_mem_size(dbg_mem_size), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_busy(dbg_busy), .dbg_rdata(dbg_rdata),
    .core_boundary(core_boundary), .core_halt(core_halt), .core_rst(core_rst),
    .core_mem_req(core_mem_req), .core_mem_we(core_mem_we),
    .core_mem_addr(core_mem_addr), .core_mem_wdata(core_mem_wdata),
    .core_mem_size(core_mem_size), .core_mem_ack(core_mem_ack),
    .core_mem_rdata(core_mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .rf_addr(rf_addr), .rf_we(rf_we),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  localparam logic [6:0] C_RESET = 7'b1000000, C_PAUSE = 7'b0100000;
  localparam logic [6:0] C_RESUME = 7'b0010000, C_MRD = 7'b0001000;
  localparam logic [6:0] C_MWR = 7'b0000100, C_RRD = 7'b0000010;
  localparam logic [6:0] C_RWR = 7'b0000001;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } wr_t;

  int n_chk = 0, n_pass = 0;
  int cyc_ctr = 0, strobe_cyc = 0, first_wr = -1;
  int rst_hi = 0, core_acks = 0, rf_we_cnt = 0, mwait = 0;
  logic [31:0] last_ack_addr = '0;
  logic [31:0] rf_mem [32];
  logic [31:0] rd_q [$];
  wr_t         wr_q [$];

  assign rf_rdata = rf_mem[rf_addr];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Memory: acks on the second consecutive request cycle.
  initial begin
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (mem_req) begin
        if (mwait == 1) begin
          mem_ack = 1'b1;
          mem_rdata = (mem_addr == 32'h100) ? 32'hCAFEF00D : ~mem_addr;
          last_ack_addr = mem_addr;
          mwait = 0;
        end else begin
          mem_ack = 1'b0; mem_rdata = '0; mwait++;
        end
      end else begin
        mem_ack = 1'b0; mem_rdata = '0; mwait = 0;
      end
    end
  end

  // Monitor: counters, register-file writes, debug write scoreboard.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      cyc_ctr++;
      if (core_rst) rst_hi++;
      if (core_mem_ack) core_acks++;
      if (rf_we) begin rf_mem[rf_addr] = rf_wdata; rf_we_cnt++; end
      if (mem_req && mem_we && first_wr < 0) first_wr = cyc_ctr;
      if (mem_req && mem_we && mem_ack) begin
        if (wr_q.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
        else begin
          e = wr_q.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_wdata, e.data);
          chk("wr_size", {30'd0, mem_size}, {30'd0, e.size});
        end
      end
    end
  end

  task automatic clr();
    dbg_valid = 1'b0;
    {dbg_reset, dbg_pause, dbg_resume, dbg_mem_rd, dbg_mem_wr,
     dbg_reg_rd, dbg_reg_wr} = '0;
  endtask

  // Drives a strobe and returns at the negedge of the strobe cycle.
  task automatic strobe(input logic [6:0] c, input logic [31:0] a,
                        input logic [31:0] w);
    @(posedge clk); #1;
    strobe_cyc = cyc_ctr + 1;
    {dbg_reset, dbg_pause, dbg_resume, dbg_mem_rd, dbg_mem_wr,
     dbg_reg_rd, dbg_reg_wr} = c;
    dbg_addr = a; dbg_wdata = w; dbg_mem_size = SIZE_WORD;
    dbg_valid = 1'b1;
    @(negedge clk);
  endtask

  // Counts busy cycles, strobe cycle included; bounded.
  task automatic idle(input string tag, output int cyc);
    cyc = 0;
    while (dbg_busy && cyc < 200) begin
      cyc++;
      @(posedge clk); #1; clr();
      @(negedge clk);
    end
    if (cyc >= 200) chk({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic finish_rd(input string tag);
    logic [31:0] e;
    e = rd_q.pop_front();
    chk(tag, dbg_rdata, e);
  endtask

  initial begin
    int c, snap, k;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
    clr(); dbg_addr = '0; dbg_wdata = '0; dbg_mem_size = '0;
    core_boundary = 1'b0; core_mem_req = 1'b0; core_mem_we = 1'b0;
    core_mem_addr = '0; core_mem_wdata = '0; core_mem_size = SIZE_WORD;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, dbg_busy}, 32'd0);
    chk("rst_halt", {31'd0, core_halt}, 32'd0);
    chk("rst_core_rst", {31'd0, core_rst}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_rdata", dbg_rdata, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Pause: boundary low for 5 cycles (from the strobe), then high.
    fork
      begin repeat (6) @(posedge clk); #1; core_boundary = 1'b1; end
    join_none
    strobe(C_PAUSE, 0, 0);
    idle("pause", c);
    chk("pause_busy_cycles", c, 32'd6);
    chk("pause_core_halt", {31'd0, core_halt}, 32'd1);

    // Halted word read at 0x100.
    rd_q.push_back(32'hCAFEF00D);
    strobe(C_MRD, 32'h100, 0);
    idle("mem_rd", c);
    chk("mem_rd_busy_cycles", c, 32'd3);
    chk("mem_rd_addr", last_ack_addr, 32'h100);
    finish_rd("mem_rd_data");

    // Register write/read while halted.
    snap = rf_we_cnt;
    strobe(C_RWR, 32'd5, 32'h1234);
    idle("reg_wr", c);
    chk("reg_wr_busy_cycles", c, 32'd2);
    chk("reg_wr_pulses", rf_we_cnt - snap, 32'd1);
    rd_q.push_back(32'h1234);
    strobe(C_RRD, 32'd5, 0);
    idle("reg_rd", c);
    finish_rd("reg_rd_x5");
    snap = rf_we_cnt;
    strobe(C_RWR, 32'd0, 32'hFFFF);
    idle("reg_wr_x0", c);
    chk("reg_wr_x0_pulses", rf_we_cnt - snap, 32'd0);

    // Resume, then a register read while running is rejected.
    strobe(C_RESUME, 0, 0);
    idle("resume", c);
    chk("resume_busy_cycles", c, 32'd1);
    chk("resume_core_halt", {31'd0, core_halt}, 32'd0);
    rd_q.push_back(32'd0);
    strobe(C_RRD, 32'd5, 0);
    idle("reg_rd_run", c);
    chk("reg_rd_run_busy", c, 32'd1);
    finish_rd("reg_rd_run_data");

    // Starvation: core hammers memory, debug write must wait for the mask.
    @(posedge clk); #1;
    core_mem_req = 1'b1; core_mem_addr = 32'h80;
    first_wr = -1;
    wr_q.push_back('{addr: 32'h300, data: 32'hDEADBEEF, size: SIZE_WORD});
    strobe(C_MWR, 32'h300, 32'hDEADBEEF);
    idle("starve", c);
    k = first_wr - strobe_cyc;
    chk("starve_grant_after_mask", {31'd0, (k >= 17 && k <= 20)}, 32'd1);
    chk("starve_wr_drained", wr_q.size(), 32'd0);
    snap = core_acks;
    repeat (8) @(negedge clk);
    chk("core_resumes", {31'd0, (core_acks - snap >= 2)}, 32'd1);
    k = 0;
    while (!core_mem_ack && k < 20) begin @(negedge clk); k++; end
    if (k >= 20) chk("core_ack_timeout", 32'd1, 32'd0);
    @(posedge clk); #1; core_mem_req = 1'b0;

    // Reset command while a pause is pending.
    core_boundary = 1'b0;
    strobe(C_PAUSE, 0, 0);
    @(posedge clk); #1; clr();
    repeat (2) @(posedge clk);
    snap = rst_hi;
    strobe(C_RESET, 0, 0);
    idle("reset_cmd", c);
    chk("reset_core_rst_cycles", rst_hi - snap, 32'd4);
    chk("reset_busy_cycles", c, 32'd5);
    chk("reset_core_halt", {31'd0, core_halt}, 32'd0);

    // rst in the middle of a granted debug read.
    strobe(C_MRD, 32'h200, 0);
    @(posedge clk); #1; clr(); rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_req_gated", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, dbg_busy}, 32'd0);
    chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_rdata", dbg_rdata, 32'd0);
    chk("rst_mid_halt", {31'd0, core_halt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; core_mem_req = 1'b1; core_mem_addr = 32'h40;
    @(negedge clk);
    chk("post_rst_fwd_req", {31'd0, mem_req}, 32'd1);
    chk("post_rst_fwd_addr", mem_addr, 32'h40);
    k = 0;
    while (!core_mem_ack && k < 20) begin @(negedge clk); k++; end
    chk("post_rst_core_ack", {31'd0, core_mem_ack}, 32'd1);
    chk("post_rst_core_rdata", core_mem_rdata, ~32'h40);
    @(posedge clk); #1; core_mem_req = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
